// File: rtl/man_seq_checker.sv
// man_seq_checker: locks onto the 8-step MAN sequence (0->4->1->3->6->2->7->5) and flags/counts deviations once locked
//   clk_i        clock, rising edge
//   rst_ni       synchronous reset, active-low
//   seq_in_i     sampled 3-bit MAN value
//   seq_valid_i  seq_in_i carries a sample this cycle
//   clr_cnt_i    synchronous clear of err_cnt_o
//   locked_o     FSM is in LOCKED
//   err_pulse_o  one-cycle flag for a mismatch seen while LOCKED
//   err_cnt_o    saturating count of LOCKED mismatches
//   expected_o   prediction for the next valid sample
module man_seq_checker #(
  parameter int LOCK_CNT = 3,
  parameter int LOSS_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [2:0]       seq_in_i,
  input  logic             seq_valid_i,
  input  logic             clr_cnt_i,
  output logic             locked_o,
  output logic             err_pulse_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic [2:0]       expected_o
);
  localparam int MX = LOCK_CNT > LOSS_CNT ? LOCK_CNT : LOSS_CNT;
  localparam int CW = $clog2(MX + 1);
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_e;
  state_e           state_q, state_d;
  logic [2:0]       exp_q, exp_d;
  logic [CW-1:0]    good_q, good_d, bad_q, bad_d;
  logic [ERR_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             match;
  function automatic logic [2:0] succ(input logic [2:0] v);
    logic [23:0] t;
    t = {3'd5, 3'd2, 3'd0, 3'd1, 3'd6, 3'd7, 3'd3, 3'd4};
    return t[v*3 +: 3];
  endfunction
  assign match = seq_in_i == exp_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= HUNT;
      exp_q   <= '0;
      good_q  <= '0;
      bad_q   <= '0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end
  // A counted mismatch coinciding with clr_cnt_i leaves the count at 1 so the error is not lost.
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    good_d  = good_q;
    bad_d   = bad_q;
    pulse_d = 1'b0;
    cnt_d   = clr_cnt_i ? '0 : cnt_q;
    if (seq_valid_i) begin
      unique case (state_q)
        HUNT: begin
          exp_d   = succ(seq_in_i);
          good_d  = '0;
          state_d = VERIFY;
        end
        VERIFY: begin
          exp_d  = succ(seq_in_i);
          good_d = match ? good_q + CW'(1) : '0;
          if (match && good_q + CW'(1) == CW'(LOCK_CNT)) begin
            state_d = LOCKED;
            bad_d   = '0;
          end
        end
        default: begin
          exp_d = succ(exp_q);
          bad_d = match ? '0 : bad_q + CW'(1);
          if (!match) begin
            pulse_d = 1'b1;
            cnt_d   = clr_cnt_i ? ERR_W'(1) : &cnt_q ? cnt_q : cnt_q + ERR_W'(1);
            state_d = bad_q + CW'(1) == CW'(LOSS_CNT) ? HUNT : LOCKED;
          end
        end
      endcase
    end
  end
  always_comb begin
    locked_o    = state_q == LOCKED;
    err_pulse_o = pulse_q;
    err_cnt_o   = cnt_q;
    expected_o  = exp_q;
  end
endmodule

// File: tb/tb_man_seq_checker.sv
// tb_man_seq_checker: scoreboard bench for man_seq_checker with a 2-bit error counter
module tb_man_seq_checker;
  localparam int LOCK = 3, LOSS = 2, EW = 2;
  logic clk = 0, rst_n = 0, vld = 0, clr = 0;
  logic [2:0] din = 0;
  logic locked, pulse;
  logic [EW-1:0] cnt;
  logic [2:0] expd;
  man_seq_checker #(.LOCK_CNT(LOCK), .LOSS_CNT(LOSS), .ERR_W(EW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .seq_in_i(din), .seq_valid_i(vld), .clr_cnt_i(clr),
    .locked_o(locked), .err_pulse_o(pulse), .err_cnt_o(cnt), .expected_o(expd)
  );
  always #5 clk = ~clk;
  typedef struct {logic l; logic p; int c; int e;} exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0;
  int m_st = 0, m_good = 0, m_bad = 0, m_cnt = 0;
  logic m_p = 0;
  logic [2:0] m_exp = 0, cur = 0;
  int man[8] = '{0, 4, 1, 3, 6, 2, 7, 5};
  function automatic logic [2:0] nxt(input logic [2:0] v);
    for (int i = 0; i < 8; i++) if (man[i] == int'(v)) return 3'(man[(i + 1) % 8]);
    return 3'd0;
  endfunction
  task automatic chk(input string tag, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask
  task automatic cyc(input logic r, input logic v, input logic [2:0] d, input logic c);
    exp_t e;
    rst_n = r; vld = v; din = d; clr = c;
    if (!r) begin
      m_st = 0; m_good = 0; m_bad = 0; m_cnt = 0; m_p = 0; m_exp = 0;
    end else begin
      m_p = 0;
      if (c) m_cnt = 0;
      if (v) begin
        if (m_st == 0) begin
          m_exp = nxt(d); m_good = 0; m_st = 1;
        end else if (m_st == 1) begin
          if (d == m_exp) begin
            m_good++;
            if (m_good == LOCK) begin m_st = 2; m_bad = 0; end
          end else m_good = 0;
          m_exp = nxt(d);
        end else begin
          if (d != m_exp) begin
            m_p = 1;
            m_cnt = c ? 1 : (m_cnt == (1 << EW) - 1 ? m_cnt : m_cnt + 1);
            m_bad++;
            if (m_bad == LOSS) m_st = 0;
          end else m_bad = 0;
          m_exp = nxt(m_exp);
        end
      end
    end
    e.l = m_st == 2; e.p = m_p; e.c = m_cnt; e.e = int'(m_exp);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) chk("sb_empty", 1, 0);
    else begin
      e = sb.pop_front();
      chk("locked", int'(locked), int'(e.l));
      chk("err_pulse", int'(pulse), int'(e.p));
      chk("err_cnt", int'(cnt), e.c);
      chk("expected", int'(expd), e.e);
    end
  endtask
  task automatic ok(input logic c = 0);
    cyc(1, 1, cur, c);
    cur = nxt(cur);
  endtask
  task automatic wrong(input logic c = 0);
    cyc(1, 1, cur ^ 3'd1, c);
    cur = nxt(cur);
  endtask
  task automatic idle();
    cyc(1, 0, 3'($urandom_range(0, 7)), 0);
  endtask
  initial begin
    cyc(0, 1, 3'd3, 1);
    cyc(0, 0, 3'd0, 0);
    cur = 0;
    for (int i = 0; i < 3; i++) ok();
    chk("t1_not_yet", int'(locked), 0);
    ok();
    chk("t1_locked", int'(locked), 1);
    for (int i = 0; i < 3; i++) ok();
    wrong();
    chk("t2_pulse", int'(pulse), 1);
    ok(); ok();
    chk("t2_cnt", int'(cnt), 1);
    chk("t2_locked", int'(locked), 1);
    cyc(1, 0, 3'd0, 1);
    wrong(); wrong();
    chk("t3_cnt", int'(cnt), 2);
    chk("t3_lost", int'(locked), 0);
    for (int i = 0; i < 1 + LOCK; i++) ok();
    chk("t3_relock", int'(locked), 1);
    cyc(0, 0, 3'd0, 0);
    foreach (man[i]) if (i < 2) begin cyc(1, 1, 3'(man[i]), 0); idle(); end
    cyc(1, 1, 3'd5, 0); idle();
    cur = 0;
    for (int i = 0; i < 3; i++) begin ok(); idle(); end
    chk("t4_locked", int'(locked), 1);
    chk("t4_quiet", int'(cnt), 0);
    for (int i = 0; i < 5; i++) begin wrong(); ok(); ok(); end
    chk("t5_sat", int'(cnt), 3);
    wrong(1);
    chk("t5_clr_err", int'(cnt), 1);
    ok(); ok();
    cyc(0, 1, cur, 0);
    cur = nxt(cur);
    chk("t6_reset", int'(locked), 0);
    for (int i = 0; i < 1 + LOCK; i++) ok();
    chk("t6_relock", int'(locked), 1);
    for (int i = 0; i < 300; i++) begin
      int r = $urandom_range(0, 19);
      if (r == 0) cyc(1, 1, 3'($urandom_range(0, 7)), 0);
      else if (r < 3) wrong(r == 2 && ($urandom_range(0, 3) == 0));
      else if (r < 6) idle();
      else if (r == 6) cyc(1, 0, cur, 1);
      else ok();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
